// File: rtl/mem_sim_pipe_if.sv
// Memory-controller command and data interface (mi_*).
//
// Handshake rules:
//   - A command (mi_addr, mi_len, mi_rw) transfers on a rising clk edge where
//     mi_valid and mi_ready are both high. The requester holds the command
//     stable while mi_valid is high and ready is low.
//   - Write data has no valid of its own. The requester presents mi_wdata and
//     mi_wmsk for the current beat during any cycle in which mi_wack is high.
//     The memory consumes them at the end of that cycle.
//   - Read data is pushed. mi_rdata is meaningful only while mi_rstb is high,
//     and the requester cannot stall it.
interface mem_sim_pipe_if #(
    parameter int AW = 20,
    parameter int DW = 32
);
    logic [AW-1:0]   mi_addr;
    logic [6:0]      mi_len;
    logic            mi_rw;
    logic            mi_valid;
    logic            mi_ready;
    logic [DW-1:0]   mi_wdata;
    logic [DW/8-1:0] mi_wmsk;
    logic            mi_wack;
    logic            mi_wlast;
    logic [DW-1:0]   mi_rdata;
    logic            mi_rstb;
    logic            mi_rlast;

    // Requester side (cache / controller).
    modport master (
        output mi_addr, mi_len, mi_rw, mi_valid, mi_wdata, mi_wmsk,
        input  mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
    );

    // Memory side.
    modport slave (
        input  mi_addr, mi_len, mi_rw, mi_valid, mi_wdata, mi_wmsk,
        output mi_ready, mi_wack, mi_wlast, mi_rdata, mi_rstb, mi_rlast
    );
endinterface

// File: rtl/mem_sim_pipe.sv
// Behavioural burst memory behind the mi_* interface.
// Features:
//   - per-byte write masks;
//   - fixed read and write latency pipelines;
//   - optional wrapping bursts;
//   - periodic refresh stalls.
// Each burst issues one beat per cycle from READ or WRITE state.
// A write burst is followed by DRAIN until its last beat has committed, so
// any later read sees every earlier write.
// The array has no reset. Array contents survive rst_n. Preloading is left to
// the surrounding environment; INIT_FILE names the file it should use.
module mem_sim_pipe #(
    parameter int AW         = 20,
    parameter int DW         = 32,
    parameter int RD_LAT     = 6,
    parameter int WR_LAT     = 2,
    parameter int WRAP_LOG2  = 0,
    parameter int REF_PERIOD = 0,
    parameter int REF_CYC    = 8,
    parameter     INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_sim_pipe_if.slave     mi,
    output logic [2:0]        dbg_state
);

    localparam int NB = DW / 8;

    // Address bits that advance within a burst. All bits advance in linear
    // mode, so the address wraps at 2^AW.
    localparam logic [AW-1:0] WRAP_MASK = (WRAP_LOG2 == 0) ? {AW{1'b1}}
                                        : AW'((64'd1 << WRAP_LOG2) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WRITE   = 3'd2,
        S_DRAIN   = 3'd3,
        S_REFRESH = 3'd4
    } state_t;

    typedef struct packed {
        logic          vld;
        logic          last;
        logic [DW-1:0] data;
    } rd_stage_t;

    typedef struct packed {
        logic          vld;
        logic          last;
        logic [AW-1:0] addr;
    } wr_stage_t;

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [6:0]    beat_q;
    logic [15:0]   wait_q;
    logic          ref_pending_q;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    rd_stage_t     rd_pipe_q [RD_LAT];
    wr_stage_t     wr_pipe_q [WR_LAT];
    rd_stage_t     rd_tail;
    wr_stage_t     wr_tail;

    logic [AW-1:0] addr_next;
    logic          rd_issue;
    logic          wr_issue;
    logic          beat_last;

    assign addr_next = (addr_q & ~WRAP_MASK) | ((addr_q + 1'b1) & WRAP_MASK);
    assign rd_issue  = (state_q == S_READ);
    assign wr_issue  = (state_q == S_WRITE);
    assign beat_last = (beat_q == 7'd0);

    // Burst sequencer: command acceptance, beat issue, write drain and refresh stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ref_pending_q) begin
                        state_q <= S_REFRESH;
                        wait_q  <= 16'(REF_CYC - 1);
                    end else if (mi.mi_valid) begin
                        addr_q  <= mi.mi_addr;
                        beat_q  <= mi.mi_len;
                        state_q <= mi.mi_rw ? S_READ : S_WRITE;
                    end
                end
                S_READ: begin
                    addr_q <= addr_next;
                    if (beat_last) state_q <= S_IDLE;
                    else           beat_q  <= beat_q - 7'd1;
                end
                S_WRITE: begin
                    addr_q <= addr_next;
                    if (beat_last) begin
                        state_q <= S_DRAIN;
                        wait_q  <= 16'(WR_LAT - 1);
                    end else begin
                        beat_q <= beat_q - 7'd1;
                    end
                end
                S_DRAIN, S_REFRESH: begin
                    if (wait_q == 16'd0) state_q <= S_IDLE;
                    else                 wait_q  <= wait_q - 16'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Refresh request generator. A new expiry wins over the clear on refresh
    // entry, because it is a genuinely new request.
    if (REF_PERIOD > 0) begin : g_ref
        logic [31:0] ref_cnt_q;

        // Free-running period counter; raises ref_pending on each expiry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ref_cnt_q     <= '0;
                ref_pending_q <= 1'b0;
            end else if (ref_cnt_q == 32'(REF_PERIOD - 1)) begin
                ref_cnt_q     <= '0;
                ref_pending_q <= 1'b1;
            end else begin
                ref_cnt_q <= ref_cnt_q + 32'd1;
                if (state_q == S_IDLE && ref_pending_q) ref_pending_q <= 1'b0;
            end
        end
    end else begin : g_no_ref
        assign ref_pending_q = 1'b0;
    end

    // Read latency pipeline. The array is sampled in the issue cycle, and the
    // beat emerges RD_LAT cycles later. Idle stages carry zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= '0;
        end else begin
            rd_pipe_q[0] <= {rd_issue, rd_issue & beat_last,
                             rd_issue ? mem[addr_q] : {DW{1'b0}}};
            for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    // Write latency pipeline. It carries the beat address to the ack cycle,
    // where the requester supplies the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WR_LAT; i++) wr_pipe_q[i] <= '0;
        end else begin
            wr_pipe_q[0] <= {wr_issue, wr_issue & beat_last, addr_q};
            for (int i = 1; i < WR_LAT; i++) wr_pipe_q[i] <= wr_pipe_q[i-1];
        end
    end

    assign rd_tail = rd_pipe_q[RD_LAT-1];
    assign wr_tail = wr_pipe_q[WR_LAT-1];

    // Array commit: enabled bytes land at the end of the mi_wack cycle.
    always_ff @(posedge clk) begin
        if (wr_tail.vld) begin
            for (int b = 0; b < NB; b++) begin
                if (mi.mi_wmsk[b]) mem[wr_tail.addr][8*b +: 8] <= mi.mi_wdata[8*b +: 8];
            end
        end
    end

    assign mi.mi_ready = rst_n & (state_q == S_IDLE) & ~ref_pending_q;
    assign mi.mi_wack  = wr_tail.vld;
    assign mi.mi_wlast = wr_tail.last;
    assign mi.mi_rstb  = rd_tail.vld;
    assign mi.mi_rlast = rd_tail.last;
    assign mi.mi_rdata = rd_tail.data;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_sim_pipe.sv
// Directed bench for mem_sim_pipe.
// Wrapping bursts (window of 4 words) and refresh (period 32, 8 cycles) are
// both enabled in this configuration.
module tb_mem_sim_pipe;

  localparam int AW         = 12;
  localparam int DW         = 32;
  localparam int RD_LAT     = 6;
  localparam int WR_LAT     = 2;
  localparam int WRAP_LOG2  = 2;
  localparam int REF_PERIOD = 32;
  localparam int REF_CYC    = 8;
  localparam int EW         = 32 + 1 + DW;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_sim_pipe_if #(.AW(AW), .DW(DW)) m ();

  mem_sim_pipe #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .WRAP_LOG2(WRAP_LOG2),
    .REF_PERIOD(REF_PERIOD), .REF_CYC(REF_CYC), .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mi(m.slave),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]        exp_q[$];   // {cycle, rlast, rdata}
  logic [32:0]          ack_q[$];   // {cycle, wlast}
  logic [DW/8+DW-1:0]   wq[$];      // {wmsk, wdata} per write beat
  logic [DW-1:0]        model [int];
  int checks   = 0;
  int failures = 0;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = a;
    r[1:0] = a[1:0] + 2'd1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_wait(input string name, input int w, input int base);
    checks++;
    if (!(w == base || w == base + 1 + REF_CYC)) begin
      failures++;
      $display("FAIL %s ready_wait got=%0d expected=%0d or %0d", name, w, base, base + 1 + REF_CYC);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge. Returns at the negedge after the accepting edge with
  // mi_valid still high, so that back-to-back commands can follow.
  task automatic issue(input bit rw, input logic [AW-1:0] a, input logic [6:0] len,
                       input logic [DW-1:0] d0, input logic [DW-1:0] step,
                       input logic [DW/8-1:0] msk, output int waits);
    logic [AW-1:0] ba;
    logic [DW-1:0] d;
    logic [DW-1:0] old;
    int c;
    m.mi_valid = 1'b1;
    m.mi_rw    = rw;
    m.mi_addr  = a;
    m.mi_len   = len;
    waits = 0;
    while (!m.mi_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!m.mi_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout addr=%h got=no_ready expected=ready", a);
      m.mi_valid = 1'b0;
      return;
    end
    c  = cyc;
    ba = a;
    for (int i = 0; i <= int'(len); i++) begin
      if (rw) begin
        exp_q.push_back({32'(c + 1 + i + RD_LAT), i == int'(len), model[int'(ba)]});
      end else begin
        d = d0 + step * DW'(i);
        wq.push_back({msk, d});
        ack_q.push_back({32'(c + 1 + i + WR_LAT), i == int'(len)});
        old = model.exists(int'(ba)) ? model[int'(ba)] : '0;
        for (int b = 0; b < DW/8; b++) if (msk[b]) old[8*b +: 8] = d[8*b +: 8];
        model[int'(ba)] = old;
      end
      ba = nxt(ba);
    end
    @(negedge clk);
  endtask

  // Write data follows mi_wack: present the next queued beat for that cycle.
  always @(negedge clk) begin
    if (m.mi_wack && wq.size() > 0) {m.mi_wmsk, m.mi_wdata} = wq.pop_front();
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [32:0]   ea;
    if (m.mi_rstb) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rstb_stray got=%h expected=no_strobe (cycle %0d)", m.mi_rdata, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({32'(cyc), m.mi_rlast, m.mi_rdata} !== e) begin
          failures++;
          $display("FAIL rbeat got cyc=%0d last=%b data=%h expected cyc=%0d last=%b data=%h",
                   cyc, m.mi_rlast, m.mi_rdata, e[EW-1 -: 32], e[DW], e[DW-1:0]);
        end
      end
    end else begin
      checks++;
      if (m.mi_rdata !== '0 || m.mi_rlast !== 1'b0) begin
        failures++;
        $display("FAIL rdata_idle got=%h/%b expected=0/0 (cycle %0d)", m.mi_rdata, m.mi_rlast, cyc);
      end
    end
    if (m.mi_wack) begin
      checks++;
      if (ack_q.size() == 0) begin
        failures++;
        $display("FAIL wack_stray got=wack expected=none (cycle %0d)", cyc);
      end else begin
        ea = ack_q.pop_front();
        if ({32'(cyc), m.mi_wlast} !== ea) begin
          failures++;
          $display("FAIL wack got cyc=%0d last=%b expected cyc=%0d last=%b",
                   cyc, m.mi_wlast, ea[32:1], ea[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int hits;
    rst_n      = 1'b0;
    m.mi_valid = 1'b0;
    m.mi_rw    = 1'b0;
    m.mi_addr  = '0;
    m.mi_len   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(m.mi_ready), 64'd0);
    chk("rst_wack",  64'({m.mi_wack, m.mi_wlast}), 64'd0);
    chk("rst_rstb",  64'({m.mi_rstb, m.mi_rlast}), 64'd0);
    chk("rst_rdata", 64'(m.mi_rdata), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(m.mi_ready), 64'd1);

    // Burst write of 0x11..0x44 at 0x10, followed immediately by a read-back.
    issue(1'b0, 12'h010, 7'd3, 32'h11, 32'h11, 4'hf, w);
    issue(1'b1, 12'h010, 7'd3, '0, '0, 4'hf, w);
    check_wait("wr4_then_rd", w, 4 + WR_LAT);
    m.mi_valid = 1'b0;

    // Byte-masked merge: 0xAABBCCDD then 0x11223344 with mask 0101 gives 0xAA22CC44.
    issue(1'b0, 12'h020, 7'd0, 32'hAABBCCDD, '0, 4'hf, w);
    issue(1'b0, 12'h020, 7'd0, 32'h11223344, '0, 4'b0101, w);
    check_wait("wr_after_wr", w, 1 + WR_LAT);
    issue(1'b1, 12'h020, 7'd0, '0, '0, 4'hf, w);
    check_wait("merge_rd", w, 1 + WR_LAT);
    m.mi_valid = 1'b0;

    // Write then read of the same word with valid held: ready is low through DRAIN.
    issue(1'b0, 12'h030, 7'd0, 32'h5A5A1234, '0, 4'hf, w);
    issue(1'b1, 12'h030, 7'd0, '0, '0, 4'hf, w);
    check_wait("drain", w, 1 + WR_LAT);
    m.mi_valid = 1'b0;

    // Wrapping burst: read from 0x6 visits 0x6, 0x7, 0x4, 0x5.
    issue(1'b0, 12'h004, 7'd3, 32'hA0000001, 32'h1, 4'hf, w);
    issue(1'b1, 12'h006, 7'd3, '0, '0, 4'hf, w);
    check_wait("wrap_rd", w, 4 + WR_LAT);
    m.mi_valid = 1'b0;

    // Continuous 2-beat reads across refresh stalls.
    hits = 0;
    issue(1'b1, 12'h010, 7'd1, '0, '0, 4'hf, w);
    for (int k = 0; k < 12; k++) begin
      issue(1'b1, 12'h010, 7'd1, '0, '0, 4'hf, w);
      check_wait("refresh_seq", w, 2);
      if (w == 2 + 1 + REF_CYC) hits++;
    end
    m.mi_valid = 1'b0;
    chk("refresh_seen", 64'(hits >= 1), 64'd1);

    // Reset during beat 2 of an 8-beat read.
    issue(1'b0, 12'h040, 7'd7, 32'hC0DE0000, 32'h1, 4'hf, w);
    issue(1'b1, 12'h040, 7'd7, '0, '0, 4'hf, w);
    m.mi_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(m.mi_ready), 64'd0);
    chk("mid_rst_strobes", 64'({m.mi_wack, m.mi_wlast, m.mi_rstb, m.mi_rlast}), 64'd0);
    chk("mid_rst_rdata", 64'(m.mi_rdata), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    exp_q.delete();
    ack_q.delete();
    wq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_rst", 64'(m.mi_ready), 64'd1);
    repeat (20) @(negedge clk);
    issue(1'b1, 12'h010, 7'd3, '0, '0, 4'hf, w);
    issue(1'b1, 12'h040, 7'd3, '0, '0, 4'hf, w);
    check_wait("rd_after_rst", w, 4);
    m.mi_valid = 1'b0;

    for (int k = 0; k < 300 && (exp_q.size() > 0 || ack_q.size() > 0); k++) @(negedge clk);
    chk("drain_exp_q", 64'(exp_q.size()), 64'd0);
    chk("drain_ack_q", 64'(ack_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
